acc_mult_seq: RTL and testbench
===============================

Name: acc_mult_seq

Overview:
- Parametrised sequential shift-add multiplier core: the next generation of the 33-bit ACC register used by the multiplier.
- Integrates the accumulator (load / add / shift-right) with its own control FSM and iteration counter. The external controller no longer drives Load/Ad/Sh.
- Operand width is generic. A Start/Busy/Done handshake connects it to the CPU's MULT path.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 2. Internal accumulator is 2*WIDTH+1 bits; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request a multiply; sampled only in IDLE.
- Multiplicando  input  WIDTH  multiplicand; captured when Start is accepted.
- Multiplicador  input  WIDTH  multiplier; captured when Start is accepted.
- Busy  output  1  high while a multiply is in progress.
- Done  output  1  one-cycle completion pulse.
- Produto  output  2*WIDTH  product register; holds its value until the next completion.

Behaviour:
- Reset: Rst=1 forces the following at once, independent of Clk: state=IDLE, ACC=0, M=0, counter=0, Busy=0, Done=0, Produto=0.
  - Reset asserted mid-operation aborts the multiply with no Done pulse.
- Registers:
  - ACC[2W:0]; the upper part is ACC[2W:W] (W+1 bits).
  - M: W+1-bit multiplicand, zero-extended.
- FSM states: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - Start=1 at edge E0: ACC <= {(W+1)'b0, Multiplicador}, M <= Multiplicando, counter <= 0, Busy <= 1, state -> ADD.
  - Start=0: hold.
- ADD: if ACC[0]=1 then ACC[2W:W] <= ACC[2W:W] + M, a (W+1)-bit add with no carry loss; else ACC is held. State -> SHIFT.
- SHIFT:
  - ACC <= ACC >> 1 (logical; 0 into bit 2W). counter <= counter+1.
  - If counter == WIDTH-1 before the increment:
    - Produto <= shifted ACC[2W-1:0], Done <= 1, Busy <= 0, state -> DONE.
  - Otherwise: state -> ADD.
- DONE: Done <= 0, state -> IDLE. Start in this cycle is ignored.
- Latency:
  - ADD at edges E(2k+1), SHIFT at E(2k+2), for k = 0..W-1.
  - Produto valid and Done=1 in the cycle after edge E2W, i.e. 2*WIDTH cycles after the accept edge.
  - Busy is high from E0 to E2W.
  - Minimum start-to-start interval is 2*WIDTH+2 cycles.
- Busy / Start rules:
  - Start while Busy=1 is ignored.
  - Operand inputs are don't-care after the accept edge.
  - Produto is not disturbed during a multiply.
- Boundaries:
  - Zero multiplier: ACC is never added; Produto=0.
  - Full-scale unsigned (all ones x all ones) must not lose the carry; this is why the upper part is W+1 bits.

Optional Feature:
- Macro: ACC_SIGNED_EN.
- Defined: operands are two's complement.
  - M <= sign-extended Multiplicando.
  - SHIFT is an arithmetic shift right (ACC[2W] replicated).
  - In the final ADD (counter == WIDTH-1) the upper part is set to ACC[2W:W] - M instead of + M when ACC[0]=1.
  - Produto is the signed 2*WIDTH-bit product. Latency and handshake are unchanged.
- Undefined: unsigned behaviour exactly as above; no subtract path is synthesised.

Test Plan:
- WIDTH=8, Rst pulse, then Start with Multiplicando=13, Multiplicador=11 -> Busy high 16 cycles; Done single pulse; Produto=143 (0x008F).
- WIDTH=8, 255 x 255 -> Produto=65025 (0xFE01), no carry loss. Follow with 7 x 0 -> Produto=0, Done after 16 cycles.
- WIDTH=8, 200 x 3 started, then Start pulsed again with 5 x 5 while Busy=1 -> second request ignored; Produto=600; only one Done pulse.
- WIDTH=8, start 100 x 100 and assert Rst at cycle 5 -> Busy=0, Produto=0 immediately, no Done. After release, 6 x 7 -> Produto=42.
- WIDTH=16, 0xFFFF x 0x0002 -> Produto=0x0001FFFE after 32 cycles. Start asserted in the DONE cycle is ignored.
- ACC_SIGNED_EN, WIDTH=8:
  - -3 x 5 -> Produto=0xFFF1 (-15).
  - -128 x -128 -> Produto=0x4000 (16384).
  - 127 x -1 -> Produto=0xFF81 (-127).

Source files
------------

// File: rtl/acc_mult_seq_if.sv
// acc_mult_seq_if: Start/Busy/Done multiply handshake bundle.
// master = CPU MULT path (drives Start/operands), slave = multiplier core.
interface acc_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic               Start;
  logic [WIDTH-1:0]   Multiplicando;
  logic [WIDTH-1:0]   Multiplicador;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] Produto;

  modport master (
    output Start, Multiplicando, Multiplicador,
    input  Busy, Done, Produto
  );

  modport slave (
    input  Start, Multiplicando, Multiplicador,
    output Busy, Done, Produto
  );
endinterface

// File: rtl/acc_mult_seq.sv
// acc_mult_seq: sequential shift-add multiplier with own FSM/counter.
// Ports: Clk, Rst (async, active-high), bus (acc_mult_seq_if.slave):
//   Start/Multiplicando/Multiplicador in; Busy/Done/Produto out.
// Optional macro ACC_SIGNED_EN: two's complement operands and product.
module acc_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic Clk,
  input  logic Rst,
  acc_mult_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int AW    = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [AW-1:0]      acc_q;
  logic [WIDTH:0]     m_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] prod_q;

  logic               last;
  logic [WIDTH:0]     upper_d;
  logic [AW-1:0]      shift_d;
  logic [WIDTH:0]     m_d;

  always_comb begin
    last = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef ACC_SIGNED_EN
    // Multiplier sign bit has negative weight: subtract on last step.
    upper_d = last ? (acc_q[AW-1:WIDTH] - m_q)
                   : (acc_q[AW-1:WIDTH] + m_q);
    shift_d = {acc_q[AW-1], acc_q[AW-1:1]};
    m_d     = {bus.Multiplicando[WIDTH-1], bus.Multiplicando};
`else
    // W+1-bit upper part keeps the carry of the add.
    upper_d = acc_q[AW-1:WIDTH] + m_q;
    shift_d = {1'b0, acc_q[AW-1:1]};
    m_d     = {1'b0, bus.Multiplicando};
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            acc_q   <= {{(WIDTH+1){1'b0}}, bus.Multiplicador};
            m_q     <= m_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (acc_q[0])
            acc_q[AW-1:WIDTH] <= upper_d;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          acc_q <= shift_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            prod_q  <= shift_d[2*WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Produto = prod_q;
endmodule

// File: tb/tb_acc_mult_seq.sv
// tb_acc_mult_seq: directed checks of acc_mult_seq at WIDTH=8 and 16.
// Expected products are hand-computed constants.
module tb_acc_mult_seq;
  logic Clk;
  logic Rst;
  int   n_cmp;
  int   n_bad;

  acc_mult_seq_if #(.WIDTH(8))  i8 ();
  acc_mult_seq_if #(.WIDTH(16)) i16 ();

  acc_mult_seq #(.WIDTH(8)) dut8 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (i8.slave)
  );

  acc_mult_seq #(.WIDTH(16)) dut16 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (i16.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mul8(input string tag,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [15:0] exp,
                      input int poke);
    int n;
    logic [15:0] prev;
    logic disturbed;
    logic busy_drop;
    @(negedge Clk);
    i8.Start = 1'b1;
    i8.Multiplicando = a;
    i8.Multiplicador = b;
    @(posedge Clk);
    #1;
    i8.Start = 1'b0;
    i8.Multiplicando = 8'hA5;
    i8.Multiplicador = 8'h5A;
    chk({tag, "_busy_up"}, i8.Busy, 1);
    prev = i8.Produto;
    disturbed = 1'b0;
    busy_drop = 1'b0;
    n = 0;
    while (i8.Done !== 1'b1 && n < 40) begin
      if (poke != 0 && n == poke) begin
        i8.Start = 1'b1;
        i8.Multiplicando = 8'd5;
        i8.Multiplicador = 8'd5;
      end else begin
        i8.Start = 1'b0;
      end
      @(posedge Clk);
      #1;
      n++;
      if (i8.Done !== 1'b1) begin
        if (i8.Produto !== prev) disturbed = 1'b1;
        if (i8.Busy !== 1'b1) busy_drop = 1'b1;
      end
    end
    i8.Start = 1'b0;
    chk({tag, "_latency"}, n, 16);
    chk({tag, "_done"}, i8.Done, 1);
    chk({tag, "_busy_dn"}, i8.Busy, 0);
    chk({tag, "_prod"}, i8.Produto, exp);
    chk({tag, "_prod_hold"}, disturbed, 0);
    chk({tag, "_busy_hold"}, busy_drop, 0);
    @(posedge Clk);
    #1;
    chk({tag, "_done_pulse"}, i8.Done, 0);
  endtask

  initial begin
    int n;
    int dones;
    n_cmp = 0;
    n_bad = 0;
    Rst = 1'b1;
    i8.Start = 1'b0;
    i8.Multiplicando = '0;
    i8.Multiplicador = '0;
    i16.Start = 1'b0;
    i16.Multiplicando = '0;
    i16.Multiplicador = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", i8.Busy, 0);
    chk("rst_done", i8.Done, 0);
    chk("rst_prod", i8.Produto, 0);
    chk("rst_prod16", i16.Produto, 0);
    @(negedge Clk);
    Rst = 1'b0;

`ifdef ACC_SIGNED_EN
    mul8("s13x11", 8'd13, 8'd11, 16'h008F, 0);
    mul8("sm3x5", 8'hFD, 8'h05, 16'hFFF1, 0);
    mul8("sm128sq", 8'h80, 8'h80, 16'h4000, 0);
    mul8("s127xm1", 8'h7F, 8'hFF, 16'hFF81, 0);
`else
    mul8("u13x11", 8'd13, 8'd11, 16'h008F, 0);
    mul8("u255sq", 8'hFF, 8'hFF, 16'hFE01, 0);
    mul8("u7x0", 8'd7, 8'd0, 16'h0000, 0);
    mul8("u200x3", 8'd200, 8'd3, 16'h0258, 3);
    dones = 0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (i8.Done === 1'b1) dones++;
    end
    chk("poke_no_2nd_done", dones, 0);
`endif

    // Abort mid-multiply with asynchronous reset.
    @(negedge Clk);
    i8.Start = 1'b1;
    i8.Multiplicando = 8'd100;
    i8.Multiplicador = 8'd100;
    @(posedge Clk);
    #1;
    i8.Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    chk("abort_busy", i8.Busy, 0);
    chk("abort_prod", i8.Produto, 0);
    chk("abort_done", i8.Done, 0);
    @(negedge Clk);
    Rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (i8.Done === 1'b1 || i8.Busy === 1'b1) dones++;
    end
    chk("abort_idle", dones, 0);
    mul8("u6x7", 8'd6, 8'd7, 16'd42, 0);

    // WIDTH=16, then Start during the DONE cycle.
    @(negedge Clk);
    i16.Start = 1'b1;
    i16.Multiplicando = 16'hFFFF;
    i16.Multiplicador = 16'h0002;
    @(posedge Clk);
    #1;
    i16.Start = 1'b0;
    chk("w16_busy_up", i16.Busy, 1);
    n = 0;
    while (i16.Done !== 1'b1 && n < 80) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("w16_latency", n, 32);
    chk("w16_done", i16.Done, 1);
`ifdef ACC_SIGNED_EN
    chk("w16_prod", i16.Produto, 32'hFFFF_FFFE);
`else
    chk("w16_prod", i16.Produto, 32'h0001_FFFE);
`endif
    i16.Start = 1'b1;
    i16.Multiplicando = 16'd3;
    i16.Multiplicador = 16'd3;
    @(posedge Clk);
    #1;
    i16.Start = 1'b0;
    chk("w16_done_start_ign", i16.Busy, 0);
    chk("w16_done_pulse", i16.Done, 0);
    @(posedge Clk);
    #1;
    chk("w16_still_idle", i16.Busy, 0);
`ifdef ACC_SIGNED_EN
    chk("w16_prod_kept", i16.Produto, 32'hFFFF_FFFE);
`else
    chk("w16_prod_kept", i16.Produto, 32'h0001_FFFE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
